time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 1000: consecutive stable cycles a synchronized button level needs before it is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 65536: idle cycles in an edit state before the edit is abandoned.
REQ-003 clock  in  1: single clock; all state updates on rising edge.
REQ-004 reset  in  1: asynchronous, active-low reset.
REQ-005 btn_mode  in  1: raw mode button, active-high, asynchronous to clock.
REQ-006 btn_inc  in  1: raw increment button, active-high, asynchronous to clock.
REQ-007 btn_dec  in  1: raw decrement button, active-high, asynchronous to clock.
REQ-008 cur_hour  in  5: running hour from the timekeeper, 0..23.
REQ-009 cur_minute  in  6: running minute from the timekeeper, 0..59.
REQ-010 set_hour  out  5: edited hour value.
REQ-011 set_minute  out  6: edited minute value.
REQ-012 load  out  1: one-cycle strobe; the timekeeper loads set_hour/set_minute and clears seconds.
REQ-013 run_flag  out  1: 1 when the timekeeper may advance; 0 while editing.
REQ-014 edit_field  out  2: 00 none, 01 hour, 10 minute; drives display blink select.

Function
REQ-015 Each button passes a 2-flop synchronizer, then debounce: accepted level changes only after DB_CYCLES consecutive identical synchronized samples.
REQ-016 A press event is a one-cycle pulse on the accepted level's 0->1 transition; holding a button produces no further events.
REQ-017 States: RUN, SET_HOUR, SET_MINUTE.
REQ-018 RUN: mode event -> capture cur_hour/cur_minute into edit registers, go SET_HOUR; inc/dec events ignored.
REQ-019 Capture clamps out-of-range inputs: hour > 23 -> 0, minute > 59 -> 0.
REQ-020 SET_HOUR: inc event -> hour+1, 23 wraps to 0; dec event -> hour-1, 0 wraps to 23; mode event -> SET_MINUTE.
REQ-021 SET_MINUTE: inc -> minute+1, 59 wraps to 0; dec -> minute-1, 0 wraps to 59; mode event -> RUN with load asserted in the transition cycle.
REQ-022 load is high exactly one cycle; set_hour/set_minute are valid that cycle and hold afterwards until the next edit.
REQ-023 Simultaneous inc and dec events in one cycle: both ignored.
REQ-024 Mode event coincident with inc or dec: the mode transition applies; inc/dec ignored.
REQ-025 Idle counter clears on every press event and on entering SET_HOUR; reaching TIMEOUT_CYCLES-1 in an edit state -> RUN, no load, edit values discarded.
REQ-026 run_flag = 1 in RUN only, registered, changing the cycle after the state transition.
REQ-027 edit_field = 01 in SET_HOUR, 10 in SET_MINUTE, 00 in RUN; value 11 is never driven.
REQ-028 All arithmetic stays at field width; no intermediate exceeds 6 bits.

Reset
REQ-029 On reset: state RUN, run_flag 1, load 0, edit_field 00, set_hour 0, set_minute 0, synchronizers/accepted levels 0, debounce and idle counters 0.
REQ-030 Reset mid-edit abandons the edit immediately with no load pulse; buttons held through reset release produce no event until released and pressed again.

Structure
REQ-031 Package time_set_pkg holds the state enumeration, edit_field encodings, HOUR_MAX=23 and MINUTE_MAX=59.
REQ-032 Sub-module btn_debounce (synchronizer, debounce counter, press pulse), parameterized by DB_CYCLES, instantiated once per button.

Verification
REQ-033 Reset, no buttons: run_flag=1, load=0, edit_field=00 for 10000 cycles.
REQ-034 cur=10:30; mode, inc x2, mode, dec x1, mode -> one load pulse with set_hour=12, set_minute=29; run_flag low from first mode until after load.
REQ-035 Hour 23 inc -> 0; hour 0 dec -> 23; minute 59 inc -> 0; minute 0 dec -> 59.
REQ-036 Bounce: btn_inc toggling every 5 cycles for 200 cycles, then high (DB_CYCLES=20) -> exactly one increment.
REQ-037 Enter SET_MINUTE, no buttons for TIMEOUT_CYCLES (set 256) -> RUN, no load, run_flag=1.
REQ-038 Inc and dec accepted in the same cycle -> value unchanged; assert reset in SET_HOUR -> RUN, load never pulses.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// time_set_pkg: state/edit-field encodings, field limits and wrap-around step helpers
package time_set_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_RUN = 2'd0;
  localparam state_t S_HOUR = 2'd1;
  localparam state_t S_MIN = 2'd2;
  localparam logic [1:0] EF_NONE = 2'b00;
  localparam logic [1:0] EF_HOUR = 2'b01;
  localparam logic [1:0] EF_MIN = 2'b10;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MINUTE_MAX = 6'd59;
  function automatic logic [4:0] step_hour(input logic [4:0] v, input logic up, input logic dn);
    return up ? (v == HOUR_MAX ? 5'd0 : v + 5'd1) : dn ? (v == 5'd0 ? HOUR_MAX : v - 5'd1) : v;
  endfunction
  function automatic logic [5:0] step_min(input logic [5:0] v, input logic up, input logic dn);
    return up ? (v == MINUTE_MAX ? 6'd0 : v + 6'd1) : dn ? (v == 6'd0 ? MINUTE_MAX : v - 6'd1) : v;
  endfunction
endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_if: buttons, running time in, edited time and status out
interface time_set_if;
  logic btn_mode;
  logic btn_inc;
  logic btn_dec;
  logic [4:0] cur_hour;
  logic [5:0] cur_minute;
  logic [4:0] set_hour;
  logic [5:0] set_minute;
  logic load;
  logic run_flag;
  logic [1:0] edit_field;
  modport master(output btn_mode, btn_inc, btn_dec, cur_hour, cur_minute,
                 input set_hour, set_minute, load, run_flag, edit_field);
  modport slave(input btn_mode, btn_inc, btn_dec, cur_hour, cur_minute,
                output set_hour, set_minute, load, run_flag, edit_field);
endinterface

// File: rtl/time_set_ctrl_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-level debounce and one-cycle press pulse
module btn_debounce #(
  parameter int DB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, armed_q, armed_d, press_q, press_d, diff, done;
  // until a stable low is seen the button is unarmed, so a press held through reset never fires
  always_comb begin
    sync_d = {sync_q[0], btn};
    diff = armed_q ? (sync_q[1] != level_q) : ~sync_q[1];
    done = diff && (cnt_q == CW'(DB_CYCLES - 1));
    cnt_d = (diff && !done) ? cnt_q + CW'(1) : '0;
    armed_d = armed_q | done;
    level_d = (armed_q && done) ? sync_q[1] : level_q;
    press_d = level_d & ~level_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: three-button hour/minute editor with load strobe and idle timeout
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DB_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input logic clk,
  input logic rst_n,
  time_set_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic mode, inc, dec, up, dn, any, timeout;
  state_t state_q, state_d;
  logic [4:0] h_q, h_d, set_h_q, set_h_d;
  logic [5:0] m_q, m_d, set_m_q, set_m_d;
  logic [TW-1:0] idle_q, idle_d;
  logic load_q, load_d, run_q, run_d;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode (.clk(clk), .rst_n(rst_n), .btn(bus.btn_mode), .press(mode));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc (.clk(clk), .rst_n(rst_n), .btn(bus.btn_inc), .press(inc));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dec (.clk(clk), .rst_n(rst_n), .btn(bus.btn_dec), .press(dec));
  always_comb begin
    up = inc & ~dec;
    dn = dec & ~inc;
    any = mode | inc | dec;
    timeout = (state_q != S_RUN) && (idle_q == TW'(TIMEOUT_CYCLES - 1));
    idle_d = (state_q == S_RUN || any) ? '0 : idle_q + TW'(1);
    state_d = state_q;
    h_d = h_q;
    m_d = m_q;
    set_h_d = set_h_q;
    set_m_d = set_m_q;
    load_d = 1'b0;
    run_d = state_q == S_RUN;
    if (state_q == S_RUN) begin
      if (mode) begin
        state_d = S_HOUR;
        h_d = bus.cur_hour > HOUR_MAX ? 5'd0 : bus.cur_hour;
        m_d = bus.cur_minute > MINUTE_MAX ? 6'd0 : bus.cur_minute;
      end
    end else if (mode) begin
      state_d = state_q == S_HOUR ? S_MIN : S_RUN;
      load_d = state_q != S_HOUR;
      set_h_d = load_d ? h_q : set_h_q;
      set_m_d = load_d ? m_q : set_m_q;
    end else if (timeout) begin
      state_d = S_RUN;
    end else if (state_q == S_HOUR) begin
      h_d = step_hour(h_q, up, dn);
    end else begin
      m_d = step_min(m_q, up, dn);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      h_q <= '0;
      m_q <= '0;
      set_h_q <= '0;
      set_m_q <= '0;
      idle_q <= '0;
      load_q <= 1'b0;
      run_q <= 1'b1;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      m_q <= m_d;
      set_h_q <= set_h_d;
      set_m_q <= set_m_d;
      idle_q <= idle_d;
      load_q <= load_d;
      run_q <= run_d;
    end
  end
  assign bus.set_hour = set_h_q;
  assign bus.set_minute = set_m_q;
  assign bus.load = load_q;
  assign bus.run_flag = run_q;
  assign bus.edit_field = state_q == S_HOUR ? EF_HOUR : state_q == S_MIN ? EF_MIN : EF_NONE;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed button sequences checked against a press-level behavioural model
module tb_time_set_ctrl;
  localparam int DB = 20;
  localparam int TO = 256;
  localparam logic [2:0] MODE = 3'b001, INC = 3'b010, DEC = 3'b100;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0, n_fail = 0;
  int m_state = 0, m_h = 0, m_m = 0, exp_h = 0, exp_m = 0, exp_loads = 0, got_loads = 0;
  bit settled = 1'b1;
  time_set_if bus();
  time_set_ctrl #(.DB_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model works at press-event level: one call per accepted button event
  task automatic model(input logic [2:0] b);
    if (b[0]) begin
      if (m_state == 0) begin
        m_state = 1;
        m_h = bus.cur_hour > 23 ? 0 : int'(bus.cur_hour);
        m_m = bus.cur_minute > 59 ? 0 : int'(bus.cur_minute);
      end else if (m_state == 1) m_state = 2;
      else begin
        m_state = 0;
        exp_loads++;
        exp_h = m_h;
        exp_m = m_m;
      end
    end else if ((b[1] ^ b[2]) && m_state != 0) begin
      if (m_state == 1) m_h = b[1] ? (m_h + 1) % 24 : (m_h + 23) % 24;
      else m_m = b[1] ? (m_m + 1) % 60 : (m_m + 59) % 60;
    end
  endtask

  task automatic drive(input logic [2:0] b, input int hi, input int lo);
    @(posedge clk); #1;
    {bus.btn_dec, bus.btn_inc, bus.btn_mode} = b;
    repeat (hi) @(posedge clk);
    #1 {bus.btn_dec, bus.btn_inc, bus.btn_mode} = 3'b000;
    repeat (lo) @(posedge clk);
  endtask

  task automatic press(input logic [2:0] b);
    settled = 1'b0;
    model(b);
    drive(b, DB + 15, DB + 15);
    #1 settled = 1'b1;
  endtask

  task automatic set_cur(input int h, input int m);
    bus.cur_hour = 5'(h);
    bus.cur_minute = 6'(m);
  endtask

  task automatic chk_set(input string nm, input int h, input int m);
    chk({nm, "_hour"}, int'(bus.set_hour), h);
    chk({nm, "_min"}, int'(bus.set_minute), m);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_load", int'(bus.load), 0);
      chk("rst_run", int'(bus.run_flag), 1);
      chk("rst_field", int'(bus.edit_field), 0);
    end else begin
      chk("field_legal", int'(bus.edit_field != 2'b11), 1);
      if (bus.load) begin
        got_loads++;
        chk("load_hour", int'(bus.set_hour), exp_h);
        chk("load_min", int'(bus.set_minute), exp_m);
      end
      if (settled) begin
        chk("field", int'(bus.edit_field), m_state);
        chk("run_flag", int'(bus.run_flag), int'(m_state == 0));
        chk("hold_hour", int'(bus.set_hour), exp_h);
        chk("hold_min", int'(bus.set_minute), exp_m);
        chk("no_load", int'(bus.load), 0);
      end
    end
  end

  initial begin
    {bus.btn_dec, bus.btn_inc, bus.btn_mode} = 3'b000;
    set_cur(10, 30);
    #2 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10000) @(posedge clk);
    #1 chk("idle_run", int'(bus.run_flag), 1);
    chk("idle_field", int'(bus.edit_field), 0);
    chk_set("idle_set", 0, 0);
    press(MODE); press(INC); press(INC); press(MODE); press(DEC); press(MODE);
    chk_set("seq_1229", 12, 29);
    set_cur(23, 59);
    press(MODE); press(INC); press(MODE); press(INC); press(MODE);
    chk_set("wrap_up", 0, 0);
    set_cur(0, 0);
    press(MODE); press(DEC); press(MODE); press(DEC); press(MODE);
    chk_set("wrap_dn", 23, 59);
    set_cur(30, 61);
    press(MODE); press(MODE); press(MODE);
    chk_set("clamp", 0, 0);
    set_cur(5, 7);
    press(MODE); press(INC | DEC); press(MODE); press(INC | DEC); press(MODE);
    chk_set("incdec", 5, 7);
    set_cur(8, 9);
    press(MODE | INC); press(INC); press(MODE | DEC); press(MODE);
    chk_set("coincide", 9, 9);
    set_cur(3, 4);
    settled = 1'b0;
    model(MODE);
    drive(MODE, DB + 15, 0);
    model(INC);
    for (int i = 0; i < 40; i++) begin
      #1 bus.btn_inc = ~i[0];
      repeat (5) @(posedge clk);
    end
    drive(INC, DB + 15, DB + 15);
    #1 settled = 1'b1;
    press(MODE); press(MODE);
    chk_set("bounce", 4, 4);
    press(MODE); press(INC); press(MODE); press(INC);
    chk("tmo_field_min", int'(bus.edit_field), 2);
    settled = 1'b0;
    repeat (TO + 40) @(posedge clk);
    m_state = 0;
    #1 settled = 1'b1;
    @(negedge clk);
    chk("tmo_run", int'(bus.run_flag), 1);
    chk_set("tmo_keep", 4, 4);
    press(MODE);
    settled = 1'b0;
    #1 bus.btn_mode = 1'b1;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    m_state = 0;
    exp_h = 0;
    exp_m = 0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1 bus.btn_mode = 1'b0;
    repeat (DB + 30) @(posedge clk);
    #1 settled = 1'b1;
    @(negedge clk);
    chk("rst_mid_field", int'(bus.edit_field), 0);
    chk_set("rst_mid_set", 0, 0);
    set_cur(1, 2);
    press(MODE); press(INC); press(MODE); press(MODE);
    chk_set("after_rst", 2, 2);
    chk("load_count_model", got_loads, exp_loads);
    chk("load_count", got_loads, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
